// File: rtl/bf16_prod_accum.sv
// Unsigned bf16 product accumulator: ACCEPT -> ALIGN -> ADD -> NORM FSM, one term per 4 cycles.
// Define BF16_ACC_RNE_EN for round-to-nearest-even in NORM; the default build truncates.
module bf16_prod_accum #(
  parameter int GUARD_W  = 3,
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf
);

  localparam int          SW      = 8 + GUARD_W;
  localparam logic [7:0]  EXP_INF = 8'(2 * EXP_BIAS + 1);
  localparam logic [15:0] POS_INF = {1'b0, EXP_INF, 7'd0};

  typedef enum logic [2:0] {ACCEPT, ALIGN, ADD, NORM, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      b_exp_q;
  logic [6:0]      b_man_q;
  logic            last_q;
  logic [15:0]     acc_q;
  logic            ovf_q;
  logic [7:0]      e_q;
  logic [SW-1:0]   sa_q, sb_q;
  logic            inf_q;
  logic [SW:0]     sum_q;

  // Right-shift a significand, folding every bit shifted out into the sticky LSB.
  function automatic logic [SW-1:0] align_sig(input logic [SW-1:0] full, input logic [7:0] diff);
    logic [SW-1:0] lost_mask;
    if (diff >= 8'(SW)) return {{(SW-1){1'b0}}, 1'b1};
    lost_mask = ~({SW{1'b1}} << diff);
    return (full >> diff) | {{(SW-1){1'b0}}, |(full & lost_mask)};
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) state_q <= ACCEPT;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ACCEPT:  if (in_valid) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = last_q ? DONE : ACCEPT;
      DONE:    if (out_ready) state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  // ---------------- ALIGN ----------------
  logic [7:0]    a_exp;
  logic          a_zero, a_inf, b_zero, b_inf;
  logic [SW-1:0] full_a, full_b;
  logic [7:0]    al_e;
  logic [SW-1:0] al_sa, al_sb;
  logic          al_inf;

  assign a_exp  = acc_q[14:7];
  assign a_zero = (a_exp == 8'd0);
  assign a_inf  = (a_exp == EXP_INF);
  assign b_zero = (b_exp_q == 8'd0);
  assign b_inf  = (b_exp_q == EXP_INF);
  assign full_a = {1'b1, acc_q[6:0], {GUARD_W{1'b0}}};
  assign full_b = {1'b1, b_man_q, {GUARD_W{1'b0}}};

  always_comb begin
    al_e   = 8'd0;
    al_sa  = '0;
    al_sb  = '0;
    al_inf = a_inf | b_inf;
    if (a_zero && !b_zero) begin
      al_e  = b_exp_q;
      al_sb = full_b;
    end else if (b_zero && !a_zero) begin
      al_e  = a_exp;
      al_sa = full_a;
    end else if (!a_zero && !b_zero) begin
      if (a_exp >= b_exp_q) begin
        al_e  = a_exp;
        al_sa = full_a;
        al_sb = align_sig(full_b, a_exp - b_exp_q);
      end else begin
        al_e  = b_exp_q;
        al_sb = full_b;
        al_sa = align_sig(full_a, b_exp_q - a_exp);
      end
    end
  end

  // ---------------- NORM ----------------
  logic          n_carry, n_up, n_zero, n_ovf;
  logic [SW-1:0] n_sig;
  logic [8:0]    n_e, n_efin, n_mant;
  logic [6:0]    n_frac;
  logic [15:0]   n_acc;

  assign n_carry = sum_q[SW];
  assign n_sig   = n_carry ? {sum_q[SW:2], sum_q[1] | sum_q[0]} : sum_q[SW-1:0];
  assign n_e     = {1'b0, e_q} + 9'(n_carry);
`ifdef BF16_ACC_RNE_EN
  assign n_up    = n_sig[GUARD_W-1] & (n_sig[GUARD_W] | (|n_sig[GUARD_W-2:0]));
`else
  assign n_up    = 1'b0;
`endif
  assign n_mant  = {1'b0, n_sig[SW-1:GUARD_W]} + 9'(n_up);
  // A rounding carry leaves 1.0000000 with the exponent bumped by one.
  assign n_efin  = n_e + 9'(n_mant[8]);
  assign n_frac  = n_mant[8] ? 7'd0 : n_mant[6:0];
  assign n_zero  = (sum_q == '0);
  assign n_ovf   = inf_q | (n_efin >= {1'b0, EXP_INF});
  assign n_acc   = n_ovf  ? POS_INF :
                   n_zero ? 16'h0000 : {1'b0, n_efin[7:0], n_frac};

  logic unused_bits;
`ifdef BF16_ACC_RNE_EN
  assign unused_bits = ^{in_data[15], n_mant[7]};
`else
  assign unused_bits = ^{in_data[15], n_mant[7], n_sig[GUARD_W-1:0]};
`endif

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_exp_q <= 8'd0;
      b_man_q <= 7'd0;
      last_q  <= 1'b0;
      acc_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      e_q     <= 8'd0;
      sa_q    <= '0;
      sb_q    <= '0;
      inf_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      unique case (state_q)
        ACCEPT: if (in_valid) begin
          b_exp_q <= in_data[14:7];
          b_man_q <= in_data[6:0];
          last_q  <= in_last;
        end
        ALIGN: begin
          e_q   <= al_e;
          sa_q  <= al_sa;
          sb_q  <= al_sb;
          inf_q <= al_inf;
        end
        ADD:  sum_q <= {1'b0, sa_q} + {1'b0, sb_q};
        NORM: begin
          acc_q <= n_acc;
          if (n_ovf) ovf_q <= 1'b1;
        end
        DONE: if (out_ready) begin
          acc_q <= 16'h0000;
          ovf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCEPT);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? acc_q : 16'h0000;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bf16_prod_accum.sv
// Scoreboard bench for bf16_prod_accum: expected sums queued at the last term, popped on out_valid.
module tb_bf16_prod_accum;

  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_ovf;
  logic [15:0] out_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int accept_cyc = 0;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    string       name;
  } exp_t;
  exp_t sb[$];

  bf16_prod_accum dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input logic [15:0] d, input logic last,
                      input logic [15:0] exp_d, input logic exp_ovf, input string nm);
    int n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    n = 0;
    while (!in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s accept: in_ready=%b, wanted 1 within %0d cycles", nm, in_ready, TIMEOUT);
    end
    accept_cyc = cyc;
    if (last) begin
      e.data = exp_d; e.ovf = exp_ovf; e.name = nm;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 16'h0000;
  endtask

  task automatic collect(output int lat);
    int n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < TIMEOUT) begin @(negedge clk); n++; end
    lat = cyc - accept_cyc;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: output seen with no expectation queued");
      return;
    end
    e = sb.pop_front();
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s out_valid timeout: got %b, wanted 1", e.name, out_valid);
      return;
    end
    vectors++;
    if (out_data !== e.data) begin
      miscompares++;
      $display("FAIL %s out_data: got %h, wanted %h", e.name, out_data, e.data);
    end
    vectors++;
    if (out_ovf !== e.ovf) begin
      miscompares++;
      $display("FAIL %s out_ovf: got %b, wanted %b", e.name, out_ovf, e.ovf);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release: out_valid=%b after take, wanted 0", e.name, out_valid);
    end
  endtask

  task automatic check_idle(input string nm);
    vectors++;
    if ({in_ready, out_valid, out_data, out_ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      miscompares++;
      $display("FAIL %s: in_ready=%b out_valid=%b out_data=%h out_ovf=%b, wanted 1 0 0000 0",
               nm, in_ready, out_valid, out_data, out_ovf);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_idle("reset_state");
  endtask

  task automatic test_basic();
    int lat;
    send(16'h3F80, 1'b0, 16'h0, 1'b0, "");
    send(16'h3F80, 1'b1, 16'h4000, 1'b0, "one_plus_one");
    collect(lat);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL latency: got %0d cycles, wanted 4", lat);
    end
    send(16'h3F80, 1'b0, 16'h0, 1'b0, "");
    send(16'h3F00, 1'b1, 16'h3FC0, 1'b0, "one_plus_half");
    collect(lat);
    send(16'h3F80, 1'b0, 16'h0, 1'b0, "");
    send(16'h8000, 1'b0, 16'h0, 1'b0, "");
    send(16'h3F80, 1'b1, 16'h4000, 1'b0, "signed_zero_term");
    collect(lat);
  endtask

  task automatic test_rounding();
    int lat;
    send(16'h3F81, 1'b0, 16'h0, 1'b0, "");
`ifdef BF16_ACC_RNE_EN
    send(16'h3B80, 1'b1, 16'h3F82, 1'b0, "round_up_odd");
`else
    send(16'h3B80, 1'b1, 16'h3F81, 1'b0, "truncate_odd");
`endif
    collect(lat);
    send(16'h3F80, 1'b0, 16'h0, 1'b0, "");
    send(16'h3B80, 1'b1, 16'h3F80, 1'b0, "tie_to_even");
    collect(lat);
    send(16'h4B00, 1'b0, 16'h0, 1'b0, "");
    send(16'h3F80, 1'b1, 16'h4B00, 1'b0, "sticky_only");
    collect(lat);
  endtask

  task automatic test_overflow();
    int lat;
    send(16'h7F00, 1'b0, 16'h0, 1'b0, "");
    send(16'h7F00, 1'b1, 16'h7F80, 1'b1, "sat_to_inf");
    collect(lat);
    send(16'h3F80, 1'b1, 16'h3F80, 1'b0, "after_ovf_clear");
    collect(lat);
    send(16'h7F80, 1'b0, 16'h0, 1'b0, "");
    send(16'h3F80, 1'b1, 16'h7F80, 1'b1, "inf_input_sticks");
    collect(lat);
  endtask

  task automatic test_single();
    int lat;
    send(16'hBF80, 1'b1, 16'h3F80, 1'b0, "single_sign_dropped");
    collect(lat);
    send(16'h0055, 1'b1, 16'h0000, 1'b0, "single_denormal");
    collect(lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < 4; i++)
      send(16'h3F80, (i == 3), 16'h4080, 1'b0, "four_ones");
    collect(lat);
  endtask

  task automatic test_backpressure();
    int lat;
    int n;
    logic [15:0] held;
    send(16'h3F80, 1'b0, 16'h0, 1'b0, "");
    send(16'h3F00, 1'b1, 16'h3FC0, 1'b0, "backpressure");
    n = 0;
    @(negedge clk);
    while (!out_valid && n < TIMEOUT) begin @(negedge clk); n++; end
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d]: out_valid=%b out_data=%h in_ready=%b, wanted 1 %h 0",
                 i, out_valid, out_data, in_ready, held);
      end
      @(negedge clk);
    end
    collect(lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    send(16'h3F80, 1'b0, 16'h0, 1'b0, "");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b, wanted 1 0", in_ready, out_valid);
    end
    rst_n = 1'b1;
    send(16'h4000, 1'b1, 16'h4000, 1'b0, "after_abort");
    collect(lat);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: %0d results outstanding, wanted 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
